gmii_frame_tx: RTL and testbench
================================

Name: gmii_frame_tx

Overview:
- GMII transmit framer feeding the gmii_tx_d/gmii_tx_en/gmii_tx_err inputs of the SGMII-to-GMII converter (triple-speed Ethernet PCS) in the 1000Base-T SFP design.
- Accepts raw frame bytes (destination MAC through payload) on a byte-wide valid/ready stream.
- Emits preamble, SFD, payload, optional padding and FCS, then enforces the inter-frame gap.
- Runs in the converter's tx_clk domain at 1000 Mb/s only (tx_clkena permanently 1).

Parameters:
- P_MIN_PAYLOAD_LEN, 60: minimum bytes before FCS; shorter frames are zero-padded up to this length; 0 disables padding.
- P_IFG_BYTES, 12: idle cycles (tx_en=0) after the last FCS byte before the next preamble; legal range 1..255.

Ports:
- i_clock  in  1  tx_clk of the PCS.
- i_reset  in  1  asynchronous, active-high reset.
- i_s_tdata  in  8  frame byte.
- i_s_tvalid  in  1  byte valid.
- o_s_tready  out  1  byte accepted when tvalid&tready.
- i_s_tlast  in  1  last byte of frame.
- i_s_tuser  in  1  abort: frame is bad; qualified with tvalid&tready.
- o_gmii_tx_d  out  8  GMII data (registered).
- o_gmii_tx_en  out  1  GMII enable (registered).
- o_gmii_tx_er  out  1  GMII error (registered).
- o_busy  out  1  high in every state except IDLE.
- o_underflow  out  1  one-cycle pulse when tvalid drops mid-frame.

Behaviour:
- Reset: state=IDLE, o_gmii_tx_d=0x00, o_gmii_tx_en=0, o_gmii_tx_er=0, o_s_tready=0, o_busy=0, o_underflow=0, CRC=0xFFFFFFFF, counters=0, IFG satisfied. Reset asserted mid-frame truncates immediately with tx_en=0 and no tx_er.
- All GMII outputs are registered: the state or byte decided in cycle N appears on the pins in cycle N+1.
- IDLE: on tvalid=1, go to PREAMBLE. The first 0x55 is on the pins the next cycle. tdata is not consumed.
- PREAMBLE: 7 cycles emitting 0x55, then SFD.
- SFD: 1 cycle emitting 0xD5. o_s_tready is asserted combinationally in this cycle and in PAYLOAD, so byte 0 follows the SFD back-to-back.
- PAYLOAD: each handshake outputs the byte, updates the CRC, and increments the byte count (16-bit, saturating).
  - tlast with count+1 < P_MIN_PAYLOAD_LEN: go to PAD.
  - tlast otherwise: go to FCS.
  - tvalid=0 while in PAYLOAD: go to ERR.
- tuser=1 on any accepted byte: that byte goes out with tx_er=1; the frame continues to tlast and the FCS is still sent (the frame is deliberately corrupt).
- PAD: emit 0x00 through the CRC until count = P_MIN_PAYLOAD_LEN, then go to FCS. o_s_tready=0.
- FCS: 4 cycles emitting ~CRC, least significant byte first.
  - CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, computed over payload and pad.
  - After the 4th byte, go to IFG.
- IFG: tx_en=0 for exactly P_IFG_BYTES cycles, counted from the first cycle after the last FCS byte on the pins; then go to IDLE. An input already valid starts its preamble in the cycle after IDLE is entered, so the minimum gap equals P_IFG_BYTES.
- ERR (underflow):
  - On the pins: one cycle with tx_en=1, tx_er=1, d=0x00; o_underflow pulses.
  - Then tx_en=0 while draining: o_s_tready=1, bytes are discarded until tlast is accepted, then go to IFG.
  - If tlast was the byte that caused entry into ERR, skip draining.
- A single-byte frame (tvalid&tlast on byte 0) is legal: pad and FCS follow.
- Frames longer than 65535 bytes: the count saturates, behaviour is otherwise unchanged.
- o_gmii_tx_er=0 in all states except the tuser and ERR cases above.

Optional Feature:
- Macro: GMII_FRAME_TX_STATS_EN.
- When defined, adds outputs o_stat_frames (32-bit), o_stat_bytes (32-bit) and o_stat_errors (16-bit). All are wrapping counters, reset to 0.
  - o_stat_frames: increments when the last FCS byte is sent for a frame with no tuser error.
  - o_stat_bytes: counts payload and pad bytes of every frame.
  - o_stat_errors: increments once per tuser-marked frame and once per underflow.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Package gmii_pkg:
  - constants GMII_PREAMBLE_BYTE=8'h55, GMII_SFD_BYTE=8'hD5, GMII_PREAMBLE_LEN=7, CRC32_POLY_REFL=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF;
  - the state enum gmii_tx_state_t {IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG, ERR};
  - function crc32_d8(crc, byte) returning the next CRC.
- One sub-module: crc32_d8_reg. It is a registered CRC with init/enable/data inputs, reused by the future gmii_frame_rx checker.

Test Plan:
- P_MIN_PAYLOAD_LEN=0, send ASCII "123456789" -> pins show 7×0x55, 0xD5, 31..39, then FCS 0x26,0x39,0xF4,0xCB; 0x55 appears 1 cycle after tvalid; tx_en is high for 21 cycles.
- Default parameters, send a 14-byte frame -> 46 bytes of 0x00 pad follow, then 4 FCS bytes; tx_en is high for 72 cycles; the FCS matches the software CRC over the 60 bytes.
- Two back-to-back 60-byte frames with tvalid held high -> exactly 12 cycles of tx_en=0 between the last FCS byte and the next 0x55.
- tvalid dropped after byte 20 of 40 ->
  - one cycle with tx_en=1, tx_er=1 and an o_underflow pulse;
  - tx_en=0 while the remaining bytes are drained;
  - the next frame starts only after a 12-cycle IFG.
- tuser=1 on byte 5 -> tx_er=1 for that byte only; the frame completes with FCS; with GMII_FRAME_TX_STATS_EN, o_stat_errors=1 and o_stat_frames=0.
- i_reset asserted during PAYLOAD -> tx_en and tx_er go low asynchronously; after release, a new frame starts cleanly with a correct FCS.

Source files
------------

// File: rtl/gmii_pkg.sv
// Shared GMII framing constants, transmit state encoding and the bytewise reflected CRC-32 step.
package gmii_pkg;

    localparam logic [7:0]  GMII_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  GMII_SFD_BYTE      = 8'hD5;
    localparam int          GMII_PREAMBLE_LEN  = 7;
    localparam logic [31:0] CRC32_POLY_REFL    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT         = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        PAYLOAD,
        PAD,
        FCS,
        IFG,
        ERR
    } gmii_tx_state_t;

    // LSB-first Ethernet CRC, one byte per call.
    function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8_reg.sv
// Registered byte-wide CRC-32 accumulator; shared by the GMII transmit framer and receive checker.
module crc32_d8_reg
    import gmii_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        init,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc <= CRC32_INIT;
        end else if (init) begin
            crc <= CRC32_INIT;
        end else if (enable) begin
            crc <= crc32_d8(crc, data);
        end
    end

endmodule

// File: rtl/gmii_frame_tx.sv
// GMII transmit framer: preamble/SFD, payload, zero pad, FCS and inter-frame gap at 1000 Mb/s.
// Optional counters are built when GMII_FRAME_TX_STATS_EN is defined.
//
// state    | meaning
// IDLE     | waiting for tvalid; CRC and byte count held at init
// PREAMBLE | 0x55 bytes on the pins
// SFD      | 0xD5 on the pins; byte 0 accepted here
// PAYLOAD  | accepted bytes forwarded and added to the CRC
// PAD      | zero bytes until the minimum length is reached
// FCS      | inverted CRC, least significant byte first
// IFG      | tx_en low for the gap time
// ERR      | underflow marked on the pins, remaining bytes drained
module gmii_frame_tx
    import gmii_pkg::*;
#(
    parameter int P_MIN_PAYLOAD_LEN = 60,
    parameter int P_IFG_BYTES       = 12
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [7:0]  i_s_tdata,
    input  logic        i_s_tvalid,
    output logic        o_s_tready,
    input  logic        i_s_tlast,
    input  logic        i_s_tuser,
    output logic [7:0]  o_gmii_tx_d,
    output logic        o_gmii_tx_en,
    output logic        o_gmii_tx_er,
    output logic        o_busy,
    output logic        o_underflow
`ifdef GMII_FRAME_TX_STATS_EN
    ,
    output logic [31:0] o_stat_frames,
    output logic [31:0] o_stat_bytes,
    output logic [15:0] o_stat_errors
`endif
);

    gmii_tx_state_t state_q, state_nxt;
    logic [2:0]  phase_q, phase_nxt;
    logic [15:0] byte_cnt_q, byte_cnt_nxt, byte_cnt_inc;
    logic [7:0]  ifg_q, ifg_nxt;
    logic [7:0]  tx_d_nxt;
    logic        tx_en_nxt, tx_er_nxt, uf_nxt;
    logic        crc_init, crc_en;
    logic [7:0]  crc_data;
    logic [31:0] crc, fcs_word;
    logic [7:0]  fcs_byte;

    crc32_d8_reg u_crc (
        .clock  (i_clock),
        .reset  (i_reset),
        .init   (crc_init),
        .enable (crc_en),
        .data   (crc_data),
        .crc    (crc)
    );

    assign byte_cnt_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
    assign fcs_word     = ~crc;
    assign o_busy       = (state_q != IDLE);

    // phase counts down 3..0 through the FCS, so 3 selects the low byte
    always_comb begin
        case (phase_q[1:0])
            2'd3:    fcs_byte = fcs_word[7:0];
            2'd2:    fcs_byte = fcs_word[15:8];
            2'd1:    fcs_byte = fcs_word[23:16];
            default: fcs_byte = fcs_word[31:24];
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            byte_cnt_q   <= '0;
            ifg_q        <= '0;
            o_gmii_tx_d  <= 8'h00;
            o_gmii_tx_en <= 1'b0;
            o_gmii_tx_er <= 1'b0;
            o_underflow  <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            phase_q      <= phase_nxt;
            byte_cnt_q   <= byte_cnt_nxt;
            ifg_q        <= ifg_nxt;
            o_gmii_tx_d  <= tx_d_nxt;
            o_gmii_tx_en <= tx_en_nxt;
            o_gmii_tx_er <= tx_er_nxt;
            o_underflow  <= uf_nxt;
        end
    end

    // Output decisions here land on the pins in the following cycle.
    always_comb begin
        state_nxt    = state_q;
        phase_nxt    = phase_q;
        byte_cnt_nxt = byte_cnt_q;
        ifg_nxt      = ifg_q;
        tx_d_nxt     = 8'h00;
        tx_en_nxt    = 1'b0;
        tx_er_nxt    = 1'b0;
        uf_nxt       = 1'b0;
        crc_init     = 1'b0;
        crc_en       = 1'b0;
        crc_data     = i_s_tdata;
        o_s_tready   = 1'b0;

        case (state_q)
            IDLE: begin
                crc_init     = 1'b1;
                byte_cnt_nxt = '0;
                if (i_s_tvalid) begin
                    tx_d_nxt  = GMII_PREAMBLE_BYTE;
                    tx_en_nxt = 1'b1;
                    phase_nxt = 3'(GMII_PREAMBLE_LEN - 1);
                    state_nxt = PREAMBLE;
                end
            end
            PREAMBLE: begin
                tx_en_nxt = 1'b1;
                if (phase_q == 3'd0) begin
                    tx_d_nxt  = GMII_SFD_BYTE;
                    state_nxt = SFD;
                end else begin
                    tx_d_nxt  = GMII_PREAMBLE_BYTE;
                    phase_nxt = phase_q - 3'd1;
                end
            end
            SFD, PAYLOAD: begin
                o_s_tready = 1'b1;
                tx_en_nxt  = 1'b1;
                if (i_s_tvalid) begin
                    tx_d_nxt     = i_s_tdata;
                    tx_er_nxt    = i_s_tuser;
                    crc_en       = 1'b1;
                    byte_cnt_nxt = byte_cnt_inc;
                    state_nxt    = PAYLOAD;
                    if (i_s_tlast) begin
                        phase_nxt = 3'd3;
                        state_nxt = (int'(byte_cnt_q) + 1 < P_MIN_PAYLOAD_LEN) ? PAD : FCS;
                    end
                end else begin
                    tx_er_nxt = 1'b1;
                    uf_nxt    = 1'b1;
                    state_nxt = ERR;
                end
            end
            PAD: begin
                tx_en_nxt    = 1'b1;
                crc_en       = 1'b1;
                crc_data     = 8'h00;
                byte_cnt_nxt = byte_cnt_inc;
                if (int'(byte_cnt_q) + 1 >= P_MIN_PAYLOAD_LEN) begin
                    phase_nxt = 3'd3;
                    state_nxt = FCS;
                end
            end
            FCS: begin
                tx_en_nxt = 1'b1;
                tx_d_nxt  = fcs_byte;
                if (phase_q == 3'd0) begin
                    ifg_nxt   = 8'(P_IFG_BYTES - 1);
                    state_nxt = IFG;
                end else begin
                    phase_nxt = phase_q - 3'd1;
                end
            end
            IFG: begin
                if (ifg_q == 8'd0) begin
                    state_nxt = IDLE;
                end else begin
                    ifg_nxt = ifg_q - 8'd1;
                end
            end
            ERR: begin
                o_s_tready = 1'b1;
                if (i_s_tvalid && i_s_tlast) begin
                    ifg_nxt   = 8'(P_IFG_BYTES - 1);
                    state_nxt = IFG;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef GMII_FRAME_TX_STATS_EN
    logic frame_err_q;
    logic tuser_first, frame_done;

    assign tuser_first = (state_q == SFD || state_q == PAYLOAD) && i_s_tvalid && i_s_tuser && !frame_err_q;
    assign frame_done  = (state_q == FCS) && (phase_q == 3'd0) && !frame_err_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            frame_err_q   <= 1'b0;
            o_stat_frames <= '0;
            o_stat_bytes  <= '0;
            o_stat_errors <= '0;
        end else begin
            if (state_q == IDLE) begin
                frame_err_q <= 1'b0;
            end else if (tuser_first) begin
                frame_err_q <= 1'b1;
            end
            if (frame_done) o_stat_frames <= o_stat_frames + 32'd1;
            if (crc_en)     o_stat_bytes  <= o_stat_bytes + 32'd1;
            if (tuser_first || uf_nxt) o_stat_errors <= o_stat_errors + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Directed-random bench for gmii_frame_tx: pin traces compared against a frame-level reference model.
module tb_gmii_frame_tx;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic       tv;
        logic       rdy;
        logic       en;
        logic       er;
        logic       uf;
        logic [7:0] d;
    } smp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [7:0] tdata = 8'h00;
    logic tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
    logic sel = 1'b0;

    logic [7:0] d0, d1;
    logic en0, en1, er0, er1, rdy0, rdy1, busy0, busy1, uf0, uf1;
    logic tvalid0, tvalid1;
    logic [7:0] m_d;
    logic m_en, m_er, m_rdy, m_busy, m_uf;

    int checks = 0;
    int failures = 0;
    smp_t trace[$];
    bit cap = 1'b0;

    always #5 clock = ~clock;

    assign tvalid0 = tvalid & ~sel;
    assign tvalid1 = tvalid & sel;
    assign m_d    = sel ? d1 : d0;
    assign m_en   = sel ? en1 : en0;
    assign m_er   = sel ? er1 : er0;
    assign m_rdy  = sel ? rdy1 : rdy0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_uf   = sel ? uf1 : uf0;

`ifdef GMII_FRAME_TX_STATS_EN
    logic [31:0] sf0, sb0, sf1, sb1;
    logic [15:0] se0, se1;
`endif

    gmii_frame_tx #(.P_MIN_PAYLOAD_LEN(0), .P_IFG_BYTES(12)) u_dut0 (
        .i_clock(clock), .i_reset(reset), .i_s_tdata(tdata), .i_s_tvalid(tvalid0),
        .o_s_tready(rdy0), .i_s_tlast(tlast), .i_s_tuser(tuser),
        .o_gmii_tx_d(d0), .o_gmii_tx_en(en0), .o_gmii_tx_er(er0),
        .o_busy(busy0), .o_underflow(uf0)
`ifdef GMII_FRAME_TX_STATS_EN
        , .o_stat_frames(sf0), .o_stat_bytes(sb0), .o_stat_errors(se0)
`endif
    );

    gmii_frame_tx #(.P_MIN_PAYLOAD_LEN(60), .P_IFG_BYTES(12)) u_dut1 (
        .i_clock(clock), .i_reset(reset), .i_s_tdata(tdata), .i_s_tvalid(tvalid1),
        .o_s_tready(rdy1), .i_s_tlast(tlast), .i_s_tuser(tuser),
        .o_gmii_tx_d(d1), .o_gmii_tx_en(en1), .o_gmii_tx_er(er1),
        .o_busy(busy1), .o_underflow(uf1)
`ifdef GMII_FRAME_TX_STATS_EN
        , .o_stat_frames(sf1), .o_stat_bytes(sb1), .o_stat_errors(se1)
`endif
    );

    // Entry j: pins after edge j, stream handshake signals as seen by edge j+1.
    always @(negedge clock) begin
        if (cap) begin
            smp_t s;
            s.tv = tvalid; s.rdy = m_rdy; s.en = m_en; s.er = m_er; s.uf = m_uf; s.d = m_d;
            trace.push_back(s);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame on the wire: preamble, SFD, payload, zero pad to minlen, ~CRC LSB first.
    function automatic bq_t build(input bq_t pl, input int minlen);
        bq_t q;
        logic [31:0] c = 32'hFFFFFFFF;
        logic [7:0] b;
        int n = pl.size();
        int total = (n > minlen) ? n : minlen;
        for (int i = 0; i < 7; i++) q.push_back(8'h55);
        q.push_back(8'hD5);
        for (int i = 0; i < total; i++) begin
            b = (i < n) ? pl[i] : 8'h00;
            q.push_back(b);
            c = c ^ {24'd0, b};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) q.push_back(c[8*k +: 8]);
        return q;
    endfunction

    function automatic bq_t rand_frame(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic int find_en(input int from);
        for (int i = from; i < trace.size(); i++) if (trace[i].en) return i;
        return -1;
    endfunction

    function automatic int run_end(input int from);
        for (int i = from; i < trace.size(); i++) if (!trace[i].en) return i;
        return trace.size();
    endfunction

    task automatic check_burst(input string tag, input int start, input bq_t exp, input int er_pos);
        int len, bad_d, bad_er;
        bad_d = 0; bad_er = 0;
        len = (start < 0) ? 0 : run_end(start) - start;
        for (int i = 0; i < len && i < exp.size(); i++) begin
            if (trace[start+i].d !== exp[i]) bad_d++;
            if (trace[start+i].er !== (i == er_pos)) bad_er++;
        end
        check({tag, "_len"}, len, exp.size());
        check({tag, "_data"}, bad_d, 0);
        check({tag, "_er"}, bad_er, 0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input bq_t pl, input int user_idx, input int drop_after,
                              input int abort_after, input bit hold);
        int budget;
        for (int i = 0; i < pl.size(); i++) begin
            if (i == abort_after) return;
            if (i == drop_after) begin
                tvalid = 1'b0;
                step();
            end
            tvalid = 1'b1;
            tdata  = pl[i];
            tlast  = (i == pl.size() - 1);
            tuser  = (i == user_idx);
            budget = 300;
            while (!m_rdy && budget > 0) begin
                step();
                budget--;
            end
            checks++;
            assert (budget > 0) else begin
                failures++;
                $error("FAIL ready_timeout observed=0 expected=1");
            end
            step();
        end
        tlast = 1'b0;
        tuser = 1'b0;
        if (!hold) tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget = 2000;
        while (m_busy && budget > 0) begin
            step();
            budget--;
        end
        checks++;
        assert (budget > 0) else begin
            failures++;
            $error("FAIL idle_timeout observed=busy expected=idle");
        end
        repeat (3) step();
    endtask

    function automatic int first_tv();
        for (int i = 0; i < trace.size(); i++) if (trace[i].tv) return i;
        return -1;
    endfunction

    initial begin
        bq_t pl, pl2, ex, ex2;
        int fe, fe2, e, h, ufc;
`ifdef GMII_FRAME_TX_STATS_EN
        logic [31:0] f_before, b_before;
        logic [15:0] e_before;
`endif

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_d", d1, 8'h00);
        check("rst_en", en1, 1'b0);
        check("rst_er", er1, 1'b0);
        check("rst_rdy", rdy1, 1'b0);
        check("rst_busy", busy1, 1'b0);
        check("rst_uf", uf1, 1'b0);
        check("rst_en0", en0, 1'b0);
        check("rst_busy0", busy0, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) step();

        // No padding: known CRC check vector
        sel = 1'b0;
        pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        trace.delete(); cap = 1'b1;
        send_frame(pl, -1, -1, -1, 1'b0);
        wait_idle();
        fe = find_en(0);
        check("ascii_latency", fe - first_tv(), 1);
        check_burst("ascii", fe, build(pl, 0), -1);
        if (fe >= 0 && fe + 20 < trace.size())
            check("ascii_fcs", {trace[fe+20].d, trace[fe+19].d, trace[fe+18].d, trace[fe+17].d}, 32'hCBF43926);

        // Short frame padded to 60
        sel = 1'b1;
        repeat (2) step();
        pl = rand_frame(14);
        trace.delete();
        send_frame(pl, -1, -1, -1, 1'b0);
        wait_idle();
        check_burst("pad14", find_en(0), build(pl, 60), -1);

        // Back-to-back 60-byte frames with tvalid held high
        pl = rand_frame(60);
        pl2 = rand_frame(60);
        trace.delete();
        send_frame(pl, -1, -1, -1, 1'b1);
        send_frame(pl2, -1, -1, -1, 1'b0);
        wait_idle();
        fe = find_en(0);
        e = run_end(fe);
        fe2 = find_en(e);
        check("b2b_gap", fe2 - e, 12);
        check_burst("b2b_f1", fe, build(pl, 60), -1);
        check_burst("b2b_f2", fe2, build(pl2, 60), -1);

        // Underflow after byte 20 of 40, then a short frame held behind it
        pl = rand_frame(40);
        pl2 = rand_frame(1 + $urandom_range(0, 20));
        trace.delete();
        send_frame(pl, -1, 20, -1, 1'b1);
        send_frame(pl2, -1, -1, -1, 1'b0);
        wait_idle();
        ex.delete();
        for (int i = 0; i < 7; i++) ex.push_back(8'h55);
        ex.push_back(8'hD5);
        for (int i = 0; i < 20; i++) ex.push_back(pl[i]);
        ex.push_back(8'h00);
        fe = find_en(0);
        e = run_end(fe);
        check_burst("uf", fe, ex, 28);
        ufc = 0;
        foreach (trace[i]) if (trace[i].uf) ufc++;
        check("uf_pulses", ufc, 1);
        if (e > 0) check("uf_pulse_pos", trace[e-1].uf, 1'b1);
        fe2 = find_en(e);
        h = -1;
        for (int i = 0; i < fe2; i++) if (trace[i].tv && trace[i].rdy) h = i;
        check("uf_drained", (h > e), 1'b1);
        check("uf_ifg", fe2 - h, 14);
        check_burst("uf_next", fe2, build(pl2, 60), -1);

        // tuser on byte 5: error only on that byte, FCS still sent
        pl = rand_frame(20);
`ifdef GMII_FRAME_TX_STATS_EN
        f_before = sf1; b_before = sb1; e_before = se1;
`endif
        trace.delete();
        send_frame(pl, 5, -1, -1, 1'b0);
        wait_idle();
        check_burst("tuser", find_en(0), build(pl, 60), 13);
`ifdef GMII_FRAME_TX_STATS_EN
        check("stat_errors", se1 - e_before, 1);
        check("stat_frames", sf1 - f_before, 0);
        check("stat_bytes", sb1 - b_before, 60);
`endif

        // Reset in PAYLOAD, then a clean frame
        pl = rand_frame(30);
        trace.delete();
        send_frame(pl, -1, -1, 10, 1'b1);
        check("rst_mid_en_before", m_en, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_en", m_en, 1'b0);
        check("rst_mid_er", m_er, 1'b0);
        check("rst_mid_busy", m_busy, 1'b0);
        check("rst_mid_rdy", m_rdy, 1'b0);
        tvalid = 1'b0;
        step();
        reset = 1'b0;
        repeat (2) step();
        pl = rand_frame(25 + $urandom_range(0, 50));
        trace.delete();
        send_frame(pl, -1, -1, -1, 1'b0);
        wait_idle();
        check_burst("post_rst", find_en(0), build(pl, 60), -1);

        cap = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
